muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_div_step.sv | 31 +++
 rtl/muldiv_unit.sv | 149 ++++++++++++++
 tb/tb_muldiv_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M multiply/divide unit.
// Op encodings follow funct3; state_e is the unit FSM.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring radix-2 divide step: shift {rem, quot}
// left, trial-subtract divisor, restore on borrow.
module muldiv_div_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quot,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quot_next
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    // Shift, trial subtract, keep or restore.
    always_comb begin
        shifted = {rem, quot[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, divisor};
        if (diff[WIDTH+1]) begin
            rem_next  = shifted[WIDTH-1:0];
            quot_next = {quot[WIDTH-2:0], 1'b0};
        end else begin
            rem_next  = diff[WIDTH-1:0];
            quot_next = {quot[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: single-cycle MUL, iterative DIV.
// MULDIV_EARLY_OUT_EN: div-by-zero/overflow bypass the DIV loop.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e             state_q, state_d;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, rem_q, quot_q, dvs_q;
    logic [WIDTH-1:0]   rem_n, quot_n, result_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               qneg_q, rneg_q, dz_q, ovf_q, zero_q;
    logic               accept, fin, early;
    logic               a_neg, b_neg, dz, ovf;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod;
    logic [WIDTH-1:0]   mul_res, div_q, div_r, div_res, fin_res;

    muldiv_div_step #(.WIDTH(WIDTH)) u_step (
        .rem       (rem_q),
        .quot      (quot_q),
        .divisor   (dvs_q),
        .rem_next  (rem_n),
        .quot_next (quot_n)
    );

    // Accept decode, operand conditioning and final result select.
    always_comb begin
        accept = start && !kill && (state_q == IDLE || state_q == DONE);
        a_neg  = !op[0] && operand_a[WIDTH-1];
        b_neg  = !op[0] && operand_b[WIDTH-1];
        abs_a  = a_neg ? -operand_a : operand_a;
        abs_b  = b_neg ? -operand_b : operand_b;
        dz     = (operand_b == '0);
        ovf    = !op[0] && (operand_a == MOST_NEG) && (operand_b == '1);
`ifdef MULDIV_EARLY_OUT_EN
        early  = dz || ovf;
`else
        early  = 1'b0;
`endif
        ext_a  = {{WIDTH{(op_q[1:0] != 2'b11) && a_q[WIDTH-1]}}, a_q};
        ext_b  = {{WIDTH{!op_q[1] && b_q[WIDTH-1]}}, b_q};
        prod   = ext_a * ext_b;
        mul_res = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0]
                                       : prod[2*WIDTH-1:WIDTH];
        div_q  = qneg_q ? -quot_q : quot_q;
        div_r  = rneg_q ? -rem_q : rem_q;
        if (dz_q) begin
            div_q = '1;
            div_r = a_q;
        end else if (ovf_q) begin
            div_q = MOST_NEG;
            div_r = '0;
        end
        div_res = op_q[1] ? div_r : div_q;
        fin_res = is_div(op_q) ? div_res : mul_res;
        fin     = !kill && (state_q == MUL ||
                  (state_q == DIV && cnt_q == '0));
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept)
                    state_d = (is_div(op) && !early) ? DIV : MUL;
                else
                    state_d = IDLE;
            end
            MUL: state_d = kill ? IDLE : DONE;
            DIV: begin
                if (kill)              state_d = IDLE;
                else if (cnt_q == '0)  state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, divide iterations and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            if (accept) begin
                op_q   <= op;
                a_q    <= operand_a;
                b_q    <= operand_b;
                rem_q  <= '0;
                quot_q <= abs_a;
                dvs_q  <= abs_b;
                cnt_q  <= CNT_W'(WIDTH);
                qneg_q <= a_neg ^ b_neg;
                rneg_q <= a_neg;
                dz_q   <= dz;
                ovf_q  <= ovf;
            end else if (state_q == DIV && cnt_q != '0) begin
                rem_q  <= rem_n;
                quot_q <= quot_n;
                cnt_q  <= cnt_q - 1'b1;
            end
            if (fin) begin
                result_q <= fin_res;
                zero_q   <= (fin_res == '0);
            end
        end
    end

    assign busy      = (state_q == MUL) || (state_q == DIV);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign zero_flag = zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32).
// Latency of special divides depends on MULDIV_EARLY_OUT_EN.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, start, kill;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done, zero_flag;
    logic [31:0] result;
    int checks = 0;
    int errors = 0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 33;
`endif

    muldiv_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .operand_a (a),
        .operand_b (b),
        .kill      (kill),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .zero_flag (zero_flag)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [2:0] o,
                         input logic [31:0] x,
                         input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk); #1;
        start = 1'b0;
        op    = 3'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; kill = 1'b0;
        op = 3'b000; a = 32'd3; b = 32'd5;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl busy=%b done=%b want 0/0", busy, done);
        end
        checks++;
        if (result !== 32'h0 || zero_flag !== 1'b1) begin
            errors++;
            $display("FAIL reset_res result=%h zf=%b want 0/1",
                     result, zero_flag);
        end
        rst = 1'b0; start = 1'b0;
    endtask

    task automatic test_mul;
        logic [2:0]  ops [3] = '{3'b000, 3'b001, 3'b011};
        logic [31:0] exp [3] = '{32'h1, 32'h0, 32'hFFFFFFFE};
        int lat;
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], 32'hFFFFFFFF, 32'hFFFFFFFF);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL mul_busy op=%0d busy=%b want 1", ops[i], busy);
            end
            wait_done(lat);
            checks++;
            if (lat !== 1 || result !== exp[i] ||
                zero_flag !== (exp[i] == 32'h0)) begin
                errors++;
                $display("FAIL mul op=%0d lat=%0d res=%h zf=%b want 1/%h",
                         ops[i], lat, result, zero_flag, exp[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mul_pulse done=%b busy=%b want 0/0",
                         done, busy);
            end
        end
    endtask

    task automatic test_div_cases(input logic [2:0] o,
                                  input logic [31:0] x,
                                  input logic [31:0] y,
                                  input logic [31:0] exp,
                                  input int exp_lat);
        int lat;
        issue(o, x, y);
        wait_done(lat);
        checks++;
        if (lat !== exp_lat || result !== exp ||
            zero_flag !== (exp == 32'h0)) begin
            errors++;
            $display("FAIL div op=%0d %h/%h lat=%0d res=%h zf=%b want %0d/%h",
                     o, x, y, lat, result, zero_flag, exp_lat, exp);
        end
    endtask

    task automatic test_div;
        test_div_cases(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        test_div_cases(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
        test_div_cases(3'b101, 32'd100, 32'd7, 32'd14, 33);
        test_div_cases(3'b111, 32'd100, 32'd7, 32'd2, 33);
        test_div_cases(3'b100, 32'd42, 32'hFFFFFFFA, 32'hFFFFFFF9, 33);
    endtask

    task automatic test_special;
        test_div_cases(3'b101, 32'd100, 32'd0, 32'hFFFFFFFF, EO_LAT);
        test_div_cases(3'b111, 32'd100, 32'd0, 32'd100, EO_LAT);
        test_div_cases(3'b100, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, EO_LAT);
        test_div_cases(3'b110, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, EO_LAT);
        test_div_cases(3'b100, 32'h80000000, 32'hFFFFFFFF,
                       32'h80000000, EO_LAT);
        test_div_cases(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, EO_LAT);
    endtask

    task automatic test_kill;
        int lat, n_done;
        issue(3'b000, 32'd7, 32'd6);
        wait_done(lat);
        issue(3'b101, 32'd100, 32'd7);
        n_done = 0;
        repeat (9) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd42) begin
            errors++;
            $display("FAIL kill busy=%b done=%b res=%h want 0/0/%h",
                     busy, done, result, 32'd42);
        end
        repeat (40) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        checks++;
        if (n_done !== 0) begin
            errors++;
            $display("FAIL kill_nodone dones=%0d want 0", n_done);
        end
        start = 1'b1; kill = 1'b1; op = 3'b000; a = 32'd2; b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL kill_idle busy=%b want 0", busy);
        end
        issue(3'b000, 32'd3, 32'd5);
        wait_done(lat);
        checks++;
        if (lat !== 1 || result !== 32'd15) begin
            errors++;
            $display("FAIL after_kill lat=%0d res=%h want 1/%h",
                     lat, result, 32'd15);
        end
    endtask

    task automatic test_reset_mid;
        issue(3'b100, 32'hFFFFFFF9, 32'd2);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 ||
            result !== 32'h0 || zero_flag !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid busy=%b done=%b res=%h zf=%b want 0/0/0/1",
                     busy, done, result, zero_flag);
        end
    endtask

    task automatic test_busy_ignore;
        int lat;
        issue(3'b101, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        checks++;
        if (lat < 0 || lat + 4 !== 33 || result !== 32'd14) begin
            errors++;
            $display("FAIL busy_ignore lat=%0d res=%h want 33/%h",
                     lat + 4, result, 32'd14);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        issue(3'b000, 32'd3, 32'd5);
        wait_done(lat);
        checks++;
        if (done !== 1'b1 || result !== 32'd15) begin
            errors++;
            $display("FAIL b2b_first done=%b res=%h want 1/%h",
                     done, result, 32'd15);
        end
        issue(3'b101, 32'd100, 32'd7);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept busy=%b want 1", busy);
        end
        wait_done(lat);
        checks++;
        if (lat !== 33 || result !== 32'd14) begin
            errors++;
            $display("FAIL b2b_second lat=%0d res=%h want 33/%h",
                     lat, result, 32'd14);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_kill();
        test_reset_mid();
        test_busy_ignore();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 checks, errors);
        $finish;
    end

endmodule
